// File: rtl/pad_ctrl_seq.sv
// Per-pad config registers plus a SAFE->RAMP->DONE sequencer that releases pads in groups.
// Pad controls and read data are registered (1 cycle); the register port never stalls (gnt_o = req_i).
module pad_ctrl_seq #(
  parameter int         NumPads    = 8,
  parameter int         GroupSize  = 3,
  parameter int         StepCycles = 4,
  parameter logic [7:0] ResetCfg   = 8'h02,
  parameter int         AddrW      = (NumPads > 1) ? $clog2(NumPads) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         release_i,
  input  logic                         safe_i,
  input  logic                         req_i,
  input  logic                         we_i,
  input  logic [AddrW-1:0]             addr_i,
  input  logic [7:0]                   wdata_i,
  output logic                         gnt_o,
  output logic                         rvalid_o,
  output logic [7:0]                   rdata_o,
  output logic [NumPads-1:0]           pad_oe_o,
  output logic [NumPads-1:0]           pad_ie_o,
  output logic [NumPads-1:0]           pad_pe_o,
  output logic [NumPads-1:0]           pad_ps_o,
  output logic [NumPads-1:0]           pad_ds0_o,
  output logic [NumPads-1:0]           pad_ds1_o,
  output logic [NumPads-1:0]           pad_sr_o,
  output logic [NumPads-1:0]           pad_is_o,
  output logic [$clog2(NumPads+1)-1:0] released_o,
  output logic                         done_o
);

  localparam int RelW   = $clog2(NumPads + 1);
  localparam int TimerW = (StepCycles > 1) ? $clog2(StepCycles) : 1;
  localparam logic [7:0]      SafeWord = 8'h04;
  localparam logic [RelW-1:0] FirstRel = RelW'((GroupSize < NumPads) ? GroupSize : NumPads);
  localparam logic [RelW-1:0] AllRel   = RelW'(NumPads);
  localparam logic [TimerW-1:0] LastTick = TimerW'(StepCycles - 1);

  typedef enum logic [1:0] {SAFE, RAMP, DONE} state_e;

  state_e            state_q;
  logic [RelW-1:0]   rel_q;
  logic [TimerW-1:0] timer_q;
  logic [7:0]        cfg_q [NumPads];
  logic [7:0]        pad_w [NumPads];
  logic [NumPads-1:0] pad_nxt [8];
  logic [RelW:0]     rel_sum;
  logic [RelW-1:0]   rel_step;
  logic              addr_ok;

  assign gnt_o      = req_i;
  assign released_o = rel_q;
  assign addr_ok    = int'(addr_i) < NumPads;

  // One extra bit so rel_q + GroupSize cannot wrap before the clamp.
  assign rel_sum  = {1'b0, rel_q} + (RelW+1)'(GroupSize);
  assign rel_step = (rel_sum >= {1'b0, AllRel}) ? AllRel : rel_sum[RelW-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SAFE;
      rel_q   <= '0;
      timer_q <= '0;
      done_o  <= 1'b0;
    end else begin
      unique case (state_q)
        SAFE: begin
          if (release_i && !safe_i) begin
            rel_q   <= FirstRel;
            timer_q <= '0;
            if (FirstRel == AllRel) begin
              state_q <= DONE;
              done_o  <= 1'b1;
            end else begin
              state_q <= RAMP;
            end
          end
        end
        RAMP: begin
          if (safe_i) begin
            state_q <= SAFE;
            rel_q   <= '0;
            timer_q <= '0;
          end else if (timer_q == LastTick) begin
            rel_q   <= rel_step;
            timer_q <= '0;
            if (rel_step == AllRel) begin
              state_q <= DONE;
              done_o  <= 1'b1;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        DONE: begin
          if (safe_i) begin
            state_q <= SAFE;
            rel_q   <= '0;
            timer_q <= '0;
            done_o  <= 1'b0;
          end
        end
        default: begin
          state_q <= SAFE;
          rel_q   <= '0;
          timer_q <= '0;
          done_o  <= 1'b0;
        end
      endcase
    end
  end

  // Reads sample cfg_q before a same-edge write; out-of-range addresses read as zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumPads; i++) cfg_q[i] <= ResetCfg;
      rvalid_o <= 1'b0;
      rdata_o  <= 8'h00;
    end else begin
      rvalid_o <= req_i;
      rdata_o  <= (req_i && !we_i && addr_ok) ? cfg_q[addr_i] : 8'h00;
      if (req_i && we_i && addr_ok) cfg_q[addr_i] <= wdata_i;
    end
  end

  for (genvar gi = 0; gi < NumPads; gi++) begin : g_pad
    assign pad_w[gi] = (rel_q > RelW'(gi)) ? cfg_q[gi] : SafeWord;
    for (genvar gb = 0; gb < 8; gb++) begin : g_bit
      assign pad_nxt[gb][gi] = pad_w[gi][gb];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pad_oe_o  <= '0;
      pad_ie_o  <= '0;
      pad_pe_o  <= '1;
      pad_ps_o  <= '0;
      pad_ds0_o <= '0;
      pad_ds1_o <= '0;
      pad_sr_o  <= '0;
      pad_is_o  <= '0;
    end else begin
      pad_oe_o  <= pad_nxt[0];
      pad_ie_o  <= pad_nxt[1];
      pad_pe_o  <= pad_nxt[2];
      pad_ps_o  <= pad_nxt[3];
      pad_ds0_o <= pad_nxt[4];
      pad_ds1_o <= pad_nxt[5];
      pad_sr_o  <= pad_nxt[6];
      pad_is_o  <= pad_nxt[7];
    end
  end

endmodule

// File: tb/tb_pad_ctrl_seq.sv
// Three pad_ctrl_seq configurations share one stimulus stream and are checked every cycle
// against an arithmetic release-schedule model, plus literal spot checks.
module tb_pad_ctrl_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rls, safe, req, we;
  logic [2:0] addr;
  logic [7:0] wdata;

  logic       gnt_a, rv_a, done_a, gnt_b, rv_b, done_b, gnt_c, rv_c, done_c;
  logic [7:0] rd_a, rd_b, rd_c;
  logic [7:0] ctl_a [8];
  logic [4:0] ctl_b [8];
  logic [7:0] ctl_c [8];
  logic [3:0] rel_a, rel_c;
  logic [2:0] rel_b;

  pad_ctrl_seq #(.NumPads(8), .GroupSize(3), .StepCycles(4), .ResetCfg(8'h02)) u_a (
    .clk_i(clk), .rst_i(rst), .release_i(rls), .safe_i(safe), .req_i(req), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt_a), .rvalid_o(rv_a), .rdata_o(rd_a),
    .pad_oe_o(ctl_a[0]), .pad_ie_o(ctl_a[1]), .pad_pe_o(ctl_a[2]), .pad_ps_o(ctl_a[3]),
    .pad_ds0_o(ctl_a[4]), .pad_ds1_o(ctl_a[5]), .pad_sr_o(ctl_a[6]), .pad_is_o(ctl_a[7]),
    .released_o(rel_a), .done_o(done_a));

  pad_ctrl_seq #(.NumPads(5), .GroupSize(3), .StepCycles(1), .ResetCfg(8'h02)) u_b (
    .clk_i(clk), .rst_i(rst), .release_i(rls), .safe_i(safe), .req_i(req), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt_b), .rvalid_o(rv_b), .rdata_o(rd_b),
    .pad_oe_o(ctl_b[0]), .pad_ie_o(ctl_b[1]), .pad_pe_o(ctl_b[2]), .pad_ps_o(ctl_b[3]),
    .pad_ds0_o(ctl_b[4]), .pad_ds1_o(ctl_b[5]), .pad_sr_o(ctl_b[6]), .pad_is_o(ctl_b[7]),
    .released_o(rel_b), .done_o(done_b));

  pad_ctrl_seq #(.NumPads(8), .GroupSize(8), .StepCycles(2), .ResetCfg(8'h5A)) u_c (
    .clk_i(clk), .rst_i(rst), .release_i(rls), .safe_i(safe), .req_i(req), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt_c), .rvalid_o(rv_c), .rdata_o(rd_c),
    .pad_oe_o(ctl_c[0]), .pad_ie_o(ctl_c[1]), .pad_pe_o(ctl_c[2]), .pad_ps_o(ctl_c[3]),
    .pad_ds0_o(ctl_c[4]), .pad_ds1_o(ctl_c[5]), .pad_sr_o(ctl_c[6]), .pad_is_o(ctl_c[7]),
    .released_o(rel_c), .done_o(done_c));

  int         np [3] = '{8, 5, 8};
  int         gs [3] = '{3, 3, 8};
  int         sc [3] = '{4, 1, 2};
  logic [7:0] rc [3] = '{8'h02, 8'h02, 8'h5A};

  // Model: a released ramp is just "k cycles since entry"; count = min(G*(1+k/S), N).
  bit         m_act [3];
  int         m_k   [3];
  logic [7:0] m_cfg [3][8];
  logic [7:0] m_pad [3][8];
  logic       m_rv  [3];
  logic [7:0] m_rd  [3];
  bit         chk_en = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic int rel_of(int j);
    int r;
    if (!m_act[j]) return 0;
    r = gs[j] * (1 + m_k[j] / sc[j]);
    return (r > np[j]) ? np[j] : r;
  endfunction

  always @(posedge clk) begin
    for (int j = 0; j < 3; j++) begin
      int r;
      r = rel_of(j);
      if (rst) begin
        for (int i = 0; i < 8; i++) begin
          m_pad[j][i] = 8'h04;
          m_cfg[j][i] = rc[j];
        end
        m_rv[j] = 1'b0;  m_rd[j] = 8'h00;
        m_act[j] = 1'b0; m_k[j] = 0;
      end else begin
        for (int i = 0; i < np[j]; i++) m_pad[j][i] = (i < r) ? m_cfg[j][i] : 8'h04;
        m_rv[j] = req;
        m_rd[j] = (req && !we && int'(addr) < np[j]) ? m_cfg[j][addr] : 8'h00;
        if (req && we && int'(addr) < np[j]) m_cfg[j][addr] = wdata;
        if (safe) begin
          m_act[j] = 1'b0; m_k[j] = 0;
        end else if (!m_act[j] && rls) begin
          m_act[j] = 1'b1; m_k[j] = 0;
        end else if (m_act[j] && m_k[j] < 1000) begin
          m_k[j] = m_k[j] + 1;
        end
      end
    end
    if (rst) chk_en = 1'b1;
  end

  task automatic chk(input string nm, input int j, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, j, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] obs_word(int j, int i);
    logic [7:0] w;
    logic [2:0] ii;
    w  = 8'h00;
    ii = 3'(i);
    for (int b = 0; b < 8; b++) begin
      case (j)
        0:       w[3'(b)] = ctl_a[b][ii];
        1:       w[3'(b)] = ctl_b[b][ii];
        default: w[3'(b)] = ctl_c[b][ii];
      endcase
    end
    return w;
  endfunction

  function automatic int obs(int j, int what);
    case (what)
      0: return (j == 0) ? int'(rel_a) : (j == 1) ? int'(rel_b) : int'(rel_c);
      1: return (j == 0) ? int'(done_a) : (j == 1) ? int'(done_b) : int'(done_c);
      2: return (j == 0) ? int'(rv_a) : (j == 1) ? int'(rv_b) : int'(rv_c);
      3: return (j == 0) ? int'(rd_a) : (j == 1) ? int'(rd_b) : int'(rd_c);
      default: return (j == 0) ? int'(gnt_a) : (j == 1) ? int'(gnt_b) : int'(gnt_c);
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int j = 0; j < 3; j++) begin
        int r;
        r = rel_of(j);
        for (int i = 0; i < np[j]; i++) chk($sformatf("pad%0d", i), j, obs_word(j, i), m_pad[j][i]);
        chk("released", j, obs(j, 0), r);
        chk("done", j, obs(j, 1), (r == np[j]) ? 1 : 0);
        chk("rvalid", j, obs(j, 2), m_rv[j]);
        chk("rdata", j, obs(j, 3), m_rd[j]);
        chk("gnt", j, obs(j, 4), req);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; rls = 1'b0; safe = 1'b0; req = 1'b0; we = 1'b0; addr = 3'd0; wdata = 8'h00;
    step(2);
    rst = 1'b0;
    step(5);
    chk("lit_rst_pe", 0, ctl_a[2], 8'hFF);
    chk("lit_rst_oe", 0, ctl_a[0], 8'h00);
    chk("lit_rst_ie", 0, ctl_a[1], 8'h00);
    chk("lit_rst_done", 0, done_a, 0);
    chk("lit_rst_rel", 0, rel_a, 0);

    for (int a = 0; a < 8; a++) begin
      req = 1'b1; we = 1'b1; addr = 3'(a); wdata = 8'h13;
      step(1);
    end
    req = 1'b0; we = 1'b0;

    rls = 1'b1; step(1); rls = 1'b0;
    chk("lit_ramp_rel_t1", 0, rel_a, 3);
    chk("lit_c_entry_done", 2, done_c, 1);
    chk("lit_c_entry_rel", 2, rel_c, 8);
    step(1);
    chk("lit_ramp_oe_t2", 0, ctl_a[0], 8'h07);
    chk("lit_b_rel_t2", 1, rel_b, 5);
    step(3);
    chk("lit_ramp_rel_t5", 0, rel_a, 6);
    chk("lit_ramp_done_t5", 0, done_a, 0);
    step(1);
    chk("lit_ramp_oe_t6", 0, ctl_a[0], 8'h3F);
    step(3);
    chk("lit_ramp_rel_t9", 0, rel_a, 8);
    chk("lit_ramp_done_t9", 0, done_a, 1);
    step(1);
    chk("lit_ramp_oe_t10", 0, ctl_a[0], 8'hFF);

    req = 1'b1; we = 1'b1; addr = 3'd2; wdata = 8'h01;
    step(1); req = 1'b0; we = 1'b0;
    chk("lit_wr_ie_t1", 0, ctl_a[1][2], 1);
    step(1);
    chk("lit_wr_ie_t2", 0, ctl_a[1][2], 0);
    req = 1'b1; addr = 3'd2;
    step(1); req = 1'b0;
    chk("lit_rd_rvalid", 0, rv_a, 1);
    chk("lit_rd_rdata", 0, rd_a, 8'h01);

    safe = 1'b1; step(1); safe = 1'b0;
    rls = 1'b1; step(1); rls = 1'b0;
    step(5);
    safe = 1'b1; step(1); safe = 1'b0;
    chk("lit_safe_rel", 0, rel_a, 0);
    chk("lit_safe_done", 0, done_a, 0);
    step(1);
    chk("lit_safe_pe", 0, ctl_a[2], 8'hFF);
    chk("lit_safe_oe", 0, ctl_a[0], 8'h00);
    rls = 1'b1; step(1); rls = 1'b0;
    step(12);
    chk("lit_rerel_oe", 0, ctl_a[0], 8'hFF);
    chk("lit_rerel_ie", 0, ctl_a[1], 8'hFB);
    chk("lit_rerel_pe", 0, ctl_a[2], 8'h00);
    chk("lit_rerel_done", 0, done_a, 1);

    req = 1'b1; we = 1'b0; addr = 3'd5;
    step(1); req = 1'b0;
    chk("lit_oor_rvalid", 1, rv_b, 1);
    chk("lit_oor_rdata", 1, rd_b, 8'h00);
    req = 1'b1; we = 1'b1; addr = 3'd5; wdata = 8'hFF;
    step(1); req = 1'b0; we = 1'b0;
    step(2);
    chk("lit_oor_oe", 1, ctl_b[0], 5'h1F);
    chk("lit_oor_ps", 1, ctl_b[3], 5'h00);

    safe = 1'b1; step(1); safe = 1'b0;
    rls = 1'b1; step(1); rls = 1'b0;
    step(2);
    rst = 1'b1; step(1); rst = 1'b0;
    chk("lit_rst_mid_rel", 0, rel_a, 0);
    step(1);
    chk("lit_rst_mid_pe", 0, ctl_a[2], 8'hFF);
    chk("lit_rst_mid_oe", 0, ctl_a[0], 8'h00);
    req = 1'b1; we = 1'b0; addr = 3'd0;
    step(1); req = 1'b0;
    chk("lit_rst_cfg_c", 2, rd_c, 8'h5A);
    chk("lit_rst_cfg_a", 0, rd_a, 8'h02);
    rls = 1'b1; step(1); rls = 1'b0;
    chk("lit_c_rerel_done", 2, done_c, 1);
    chk("lit_c_rerel_rel", 2, rel_c, 8);
    chk("lit_a_rerel_rel", 0, rel_a, 3);

    for (int n = 0; n < 3000; n++) begin
      req   = 1'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      addr  = 3'($urandom_range(0, 7));
      wdata = 8'($urandom);
      rls   = ($urandom_range(0, 7) == 0);
      safe  = ($urandom_range(0, 39) == 0);
      rst   = ($urandom_range(0, 299) == 0);
      step(1);
    end
    rst = 1'b0; rls = 1'b0; safe = 1'b0; req = 1'b0; we = 1'b0;
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
